// File: rtl/pc_seq_if.sv
// Fetch-side bundle between the PC sequencer and its pipeline: control requests in, PC and status out.
interface pc_seq_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            exc_i;
    logic            call_i;
    logic            ret_i;
    logic [XLEN-1:0] pc_o;
    logic            pc_valid_o;
    logic            misalign_o;
    logic            ras_full_o;
    logic            ras_empty_o;

    modport master (
        output stall_i, redirect_i, redirect_pc_i, exc_i, call_i, ret_i,
        input  pc_o, pc_valid_o, misalign_o, ras_full_o, ras_empty_o
    );

    modport slave (
        input  stall_i, redirect_i, redirect_pc_i, exc_i, call_i, ret_i,
        output pc_o, pc_valid_o, misalign_o, ras_full_o, ras_empty_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: exception > redirect > stall > RAS return > pc+4.
// The return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] EXC_VEC   = 32'h0000_0080,
    parameter int              RAS_DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    pc_seq_if.slave  bus
);
    logic [XLEN-1:0] pc_q, pc_d, seq_pc;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;

`ifdef PC_SEQ_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [PW-1:0]   ras_wp_q, ras_wp_d, ras_top, ras_waddr;
    logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
    logic            ras_we, ras_empty;
`endif

    always_comb begin
        seq_pc     = pc_q + XLEN'(4);
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        misalign_d = 1'b0;
`ifdef PC_SEQ_RAS_EN
        ras_wp_d   = ras_wp_q;
        ras_cnt_d  = ras_cnt_q;
        ras_top    = ras_wp_q - PW'(1);
        ras_waddr  = ras_wp_q;
        ras_we     = 1'b0;
        ras_empty  = (ras_cnt_q == '0);
`endif
        // First edge after reset release only raises pc_valid; PC stays at RESET_VEC.
        if (!pc_valid_q) begin
            pc_d = pc_q;
        end else if (bus.exc_i) begin
            pc_d = EXC_VEC;
`ifdef PC_SEQ_RAS_EN
            ras_cnt_d = '0;
            ras_wp_d  = '0;
`endif
        end else if (bus.redirect_i) begin
            pc_d       = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
            misalign_d = |bus.redirect_pc_i[1:0];
        end else if (bus.stall_i) begin
            pc_d = pc_q;
        end else begin
            pc_d = seq_pc;
`ifdef PC_SEQ_RAS_EN
            if (bus.call_i && bus.ret_i && !ras_empty) begin
                // Return and call in one fetch: consume the top and replace it in place.
                pc_d      = ras_mem_q[ras_top];
                ras_we    = 1'b1;
                ras_waddr = ras_top;
            end else if (bus.call_i) begin
                ras_we   = 1'b1;
                ras_wp_d = ras_wp_q + PW'(1);
                if (ras_cnt_q != CW'(RAS_DEPTH)) begin
                    ras_cnt_d = ras_cnt_q + CW'(1);
                end
            end else if (bus.ret_i && !ras_empty) begin
                pc_d      = ras_mem_q[ras_top];
                ras_wp_d  = ras_top;
                ras_cnt_d = ras_cnt_q - CW'(1);
            end
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
`ifdef PC_SEQ_RAS_EN
            ras_wp_q   <= '0;
            ras_cnt_q  <= '0;
`endif
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
`ifdef PC_SEQ_RAS_EN
            ras_wp_q   <= ras_wp_d;
            ras_cnt_q  <= ras_cnt_d;
`endif
        end
    end

`ifdef PC_SEQ_RAS_EN
    // Circular storage: when full, the write pointer lands on the oldest entry.
    always_ff @(posedge clk_i) begin
        if (ras_we) begin
            ras_mem_q[ras_waddr] <= seq_pc;
        end
    end

    assign bus.ras_full_o  = (ras_cnt_q == CW'(RAS_DEPTH));
    assign bus.ras_empty_o = (ras_cnt_q == '0);
`else
    logic unused_ras_in;
    assign unused_ras_in   = ^{bus.call_i, bus.ret_i};
    assign bus.ras_full_o  = 1'b0;
    assign bus.ras_empty_o = 1'b1;
`endif

    assign bus.pc_o       = pc_q;
    assign bus.pc_valid_o = pc_valid_q;
    assign bus.misalign_o = misalign_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: table of single-cycle vectors plus reset and RAS sequences.
module tb_pc_sequencer;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_bad;

    pc_seq_if #(.XLEN(32)) bus ();

    pc_sequencer #(.XLEN(32)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ex;
        logic        ca;
        logic        re;
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic ex, input logic ca, input logic re);
        bus.stall_i       = st;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
        bus.exc_i         = ex;
        bus.call_i        = ca;
        bus.ret_i         = re;
    endtask

    task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic ex, input logic ca, input logic re);
        drive(st, rd, rpc, ex, ca, re);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string nm, input logic [31:0] pc, input logic mis,
                          input logic empty, input logic full);
        chk({nm, "_pc"}, bus.pc_o, pc);
        chk1({nm, "_mis"}, bus.misalign_o, mis);
        chk1({nm, "_empty"}, bus.ras_empty_o, empty);
        chk1({nm, "_full"}, bus.ras_full_o, full);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        // st rd rpc ex ca re -> pc mis ; starting from pc=0x8
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_000C, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0000_000C, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0000_000C, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 32'h10,        1'b0, 1'b0, 1'b0, 32'h0000_0010, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 32'h43,        1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0040, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0044, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 32'h1E,        1'b0, 1'b1, 1'b0, 32'h0000_001C, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 32'h20,        1'b0, 1'b0, 1'b1, 32'h0000_0020, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h300,       1'b1, 1'b0, 1'b0, 32'h0000_0080, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0084, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 32'h7,         1'b1, 1'b0, 1'b0, 32'h0000_0080, 1'b0};

        // Power-on reset
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("por_pc", bus.pc_o, 32'h0);
        chk1("por_valid", bus.pc_valid_o, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_pc("por_hold", 32'h0, 1'b0, 1'b1, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk1("rel1_valid", bus.pc_valid_o, 1'b1);
        chk("rel1_pc", bus.pc_o, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rel2_pc", bus.pc_o, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rel3_pc", bus.pc_o, 32'h8);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].st, tbl[i].rd, tbl[i].rpc, tbl[i].ex, tbl[i].ca, tbl[i].re);
            chk_pc($sformatf("v%0d", i), tbl[i].pc, tbl[i].mis, 1'b1, 1'b0);
            chk1($sformatf("v%0d_valid", i), bus.pc_valid_o, 1'b1);
        end

        // Reset mid-stall with a misaligned redirect pending
        step(1'b1, 1'b1, 32'h0000_0243, 1'b0, 1'b0, 1'b0);
        chk_pc("pre_rst", 32'h240, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_pc("mid_rst", 32'h0, 1'b0, 1'b1, 1'b0);
        chk1("mid_rst_valid", bus.pc_valid_o, 1'b0);
        @(posedge clk);
        #1;
        chk("mid_rst_edge_pc", bus.pc_o, 32'h0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk1("rr1_valid", bus.pc_valid_o, 1'b1);
        chk("rr1_pc", bus.pc_o, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rr2_pc", bus.pc_o, 32'h4);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("rr3_pc", bus.pc_o, 32'h8);

`ifdef PC_SEQ_RAS_EN
        // Five calls into a four-deep stack, then five returns
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 1'b1, 32'(k) << 8, 1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
            chk_pc($sformatf("call%0d", k), (32'(k) << 8) + 32'h4, 1'b0, 1'b0, (k >= 4));
        end
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("ret1", 32'h504, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("ret2", 32'h404, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("ret3", 32'h304, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("ret4", 32'h204, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("ret5", 32'h208, 1'b0, 1'b1, 1'b0);

        // Simultaneous call+ret, with and without a stacked entry
        step(1'b0, 1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk_pc("cr_push", 32'h604, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk_pc("cr_swap", 32'h604, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("cr_ret", 32'h608, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk_pc("cr_empty", 32'h60C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk_pc("stall_call", 32'h60C, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk_pc("exc_clear", 32'h80, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("exc_ret", 32'h84, 1'b0, 1'b1, 1'b0);
`else
        // Without the stack, call/ret have no effect on sequencing
        step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk_pc("nras_call", 32'h104, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk_pc("nras_ret", 32'h108, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        chk_pc("nras_both", 32'h10C, 1'b0, 1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
